// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared field layout, write-size code and reload helper for the fractional divider
package clk_div_pkg;
  localparam int CWordW = 32;
  localparam int CFraLo = 0;
  localparam int CEnBit = 31;
  localparam logic [3:0] CWrSize32 = 4'h4;
  function automatic logic [CWordW:0] int_carry(input logic [CWordW-1:0] int_f, input logic carry);
    return {1'b0, int_f} + {{CWordW{1'b0}}, carry};
  endfunction
endpackage

// File: rtl/clk_div_frac_ch.sv
// clk_div_frac_ch: one fractional divider channel; reloads only at period boundaries
module clk_div_frac_ch
  import clk_div_pkg::*;
#(
  parameter int CIntW = 12,
  parameter int CFraW = 4,
  parameter logic [CWordW-1:0] CResetDiv = 32'h8000_0170
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic [CWordW-1:0] shadow_i,
  output logic              clk_o,
  output logic              tick_o
);
  logic [CWordW-1:0] active_q, active_d, word;
  logic [CIntW:0] cnt_q, cnt_d, load;
  logic [CFraW-1:0] acc_q, acc_d;
  logic [CFraW:0] sum;
  logic clk_q, clk_d, tick_q, tick_d, boundary, fire, unused_word;
  assign unused_word = ^word;
  always_comb begin
    boundary = cnt_q == '0 && !clk_q;
    word = boundary ? shadow_i : active_q;
    sum = {1'b0, acc_q} + {1'b0, word[CFraLo +: CFraW]};
    load = (CIntW+1)'(int_carry(CWordW'(word[CFraLo+CFraW +: CIntW]), sum[CFraW]));
    // fire: start of a high phase (enabled boundary) or end of a high phase
    fire = boundary ? word[CEnBit] : cnt_q == '0;
    active_d = boundary && !sync_i ? shadow_i : active_q;
    cnt_d = sync_i || (boundary && !fire) ? '0 : fire ? load : cnt_q - (CIntW+1)'(1);
    acc_d = sync_i || (boundary && !fire) ? '0 : fire ? sum[CFraW-1:0] : acc_q;
    clk_d = !sync_i && (fire ? boundary : clk_q);
    tick_d = !sync_i && boundary && fire;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active_q <= CResetDiv;
      cnt_q <= '0;
      acc_q <= '0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else if (en_i) begin
      active_q <= active_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
    end
  assign clk_o = clk_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clk_div_frac_mc.sv
// clk_div_frac_mc: multi-channel IO-programmable fractional clock divider with common restart
module clk_div_frac_mc
  import clk_div_pkg::*;
#(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int CChCnt = 4,
  parameter int CIntW = 12,
  parameter int CFraW = 4,
  parameter logic [CWordW-1:0] CResetDiv = 32'h8000_0170
) (
  input  logic              AClkH,
  input  logic              AResetHN,
  input  logic              AClkHEn,
  input  logic [15:0]       AIoAddr,
  input  logic [63:0]       AIoMosi,
  input  logic [3:0]        AIoWrSize,
  output logic              AIoAddrAck,
  output logic              AIoAddrErr,
  input  logic              ASyncI,
  output logic [CChCnt-1:0] AClkOut,
  output logic [CChCnt-1:0] AClkEnO
);
  logic [15:0] off;
  logic unused_mosi;
  assign off = AIoAddr - CAddrBase;
  assign AIoAddrAck = AIoAddr >= CAddrBase && off < 16'(4*CChCnt);
  assign AIoAddrErr = AIoAddrAck && AIoWrSize != 4'h0 && AIoWrSize != CWrSize32;
  assign unused_mosi = ^AIoMosi[63:CWordW];
  for (genvar n = 0; n < CChCnt; n++) begin : g_ch
    logic [CWordW-1:0] shadow_q, shadow_d;
    assign shadow_d = AIoAddrAck && AIoWrSize == CWrSize32 && off[4:2] == 3'(n)
                      ? AIoMosi[CWordW-1:0] : shadow_q;
    always_ff @(posedge AClkH or negedge AResetHN)
      if (!AResetHN) shadow_q <= CResetDiv;
      else if (AClkHEn) shadow_q <= shadow_d;
    clk_div_frac_ch #(
      .CIntW(CIntW),
      .CFraW(CFraW),
      .CResetDiv(CResetDiv)
    ) u_ch (
      .clk(AClkH),
      .rst_n(AResetHN),
      .en_i(AClkHEn),
      .sync_i(ASyncI),
      .shadow_i(shadow_q),
      .clk_o(AClkOut[n]),
      .tick_o(AClkEnO[n])
    );
  end
endmodule

// File: tb/tb_clk_div_frac_mc.sv
// tb_clk_div_frac_mc: directed checks of divide ratios, reload timing, restart, gating and IO decode
module tb_clk_div_frac_mc;
  logic AClkH = 1'b0;
  logic AResetHN, AClkHEn, ASyncI, AIoAddrAck, AIoAddrErr;
  logic [15:0] AIoAddr;
  logic [63:0] AIoMosi;
  logic [3:0] AIoWrSize, AClkOut, AClkEnO, exp_clk, exp_en;
  logic ch1c, ch1t;
  int checks = 0, errors = 0, cyc = 0, p;

  clk_div_frac_mc dut (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn),
    .AIoAddr(AIoAddr), .AIoMosi(AIoMosi), .AIoWrSize(AIoWrSize),
    .AIoAddrAck(AIoAddrAck), .AIoAddrErr(AIoAddrErr),
    .ASyncI(ASyncI), .AClkOut(AClkOut), .AClkEnO(AClkEnO)
  );

  always #5 AClkH = ~AClkH;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] c, input logic [3:0] e);
    chk({tag, "_clk"}, 32'(AClkOut), 32'(c));
    chk({tag, "_en"}, 32'(AClkEnO), 32'(e));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge AClkH);
      cyc++;
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) step(1);
  endtask

  task automatic io_chk(input logic [15:0] a, input logic [3:0] s, input logic ack, input logic err);
    AIoAddr = a;
    AIoWrSize = s;
    #1;
    chk("ack", 32'(AIoAddrAck), 32'(ack));
    chk("err", 32'(AIoAddrErr), 32'(err));
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic ack, input logic err);
    AIoMosi = {32'hDEAD_BEEF, d};
    io_chk(a, s, ack, err);
    step(1);
    AIoWrSize = 4'h0;
  endtask

  initial begin
    AResetHN = 1'b0;
    AClkHEn = 1'b1;
    ASyncI = 1'b0;
    AIoAddr = '0;
    AIoMosi = '0;
    AIoWrSize = 4'h0;
    repeat (3) @(negedge AClkH);
    chk_out("rst", 4'h0, 4'h0);
    io_chk(16'h000F, 4'h4, 1'b1, 1'b0);
    io_chk(16'h0010, 4'h2, 1'b0, 1'b0);
    io_chk(16'h0004, 4'h2, 1'b1, 1'b1);
    io_chk(16'h0000, 4'h0, 1'b1, 1'b0);
    io_chk(16'hFFFC, 4'h4, 1'b0, 1'b0);
    AIoWrSize = 4'h0;
    @(negedge AClkH);
    AResetHN = 1'b1;
    cyc = 0;
    // default divider: all channels rise together, 24 high / 24 low
    step(1);
    chk_out("rise0", 4'hF, 4'hF);
    step(1);
    chk_out("high0", 4'hF, 4'h0);
    wr(16'h0004, 32'h8000_0038, 4'h4, 1'b1, 1'b0);
    wr(16'h0008, 32'h8000_0000, 4'h4, 1'b1, 1'b0);
    wr(16'h002C, 32'h8000_0000, 4'h4, 1'b0, 1'b0);
    wr(16'h000C, 32'h8000_0000, 4'h2, 1'b1, 1'b1);
    wait_to(24);
    chk_out("last_high", 4'hF, 4'h0);
    step(1);
    chk_out("first_low", 4'h0, 4'h0);
    wait_to(48);
    chk_out("last_low", 4'h0, 4'h0);
    wait_to(49);
    // ch1 alternates 4/5 half-periods, ch2 divides by 2, ch0/ch3 stay on 48
    while (cyc <= 66) begin
      p = cyc - 49;
      exp_clk = {1'b1, cyc[0], (p % 9) < 4, 1'b1};
      exp_en = {cyc == 49, cyc[0], (p % 9) == 0, cyc == 49};
      chk_out("frac", exp_clk, exp_en);
      if (cyc == 66) wr(16'h0004, 32'h8000_0010, 4'h4, 1'b1, 1'b0);
      else step(1);
    end
    chk_out("bnd_wr", 4'hF, 4'h6);
    wr(16'h0008, 32'h0000_0000, 4'h4, 1'b1, 1'b0);
    while (cyc <= 85) begin
      ch1c = cyc <= 70 ? 1'b1 : cyc <= 75 ? 1'b0 : ((cyc - 76) % 4) < 2;
      ch1t = cyc == 76 || cyc == 80 || cyc == 84;
      exp_clk = {cyc <= 72, 1'b0, ch1c, cyc <= 72};
      exp_en = {2'b00, ch1t, 1'b0};
      chk_out("newdiv", exp_clk, exp_en);
      step(1);
    end
    ASyncI = 1'b1;
    step(1);
    ASyncI = 1'b0;
    chk_out("sync1", 4'h0, 4'h0);
    step(1);
    chk_out("sync2", 4'hB, 4'hB);
    step(1);
    chk_out("sync3", 4'hB, 4'h0);
    step(1);
    chk_out("sync4", 4'h9, 4'h0);
    wait_to(92);
    chk_out("pre_frz", 4'hB, 4'h2);
    AClkHEn = 1'b0;
    while (cyc < 102) begin
      if (cyc == 95) wr(16'h0000, 32'h8000_0000, 4'h4, 1'b1, 1'b0);
      else step(1);
      chk_out("frz", 4'hB, 4'h2);
    end
    AClkHEn = 1'b1;
    step(1);
    chk_out("res1", 4'hB, 4'h0);
    step(1);
    chk_out("res2", 4'h9, 4'h0);
    wait_to(106);
    chk_out("res3", 4'hB, 4'h2);
    wait_to(121);
    chk_out("res_hi", 4'h9, 4'h0);
    step(1);
    chk_out("res_lo", 4'h2, 4'h2);
    wait_to(145);
    chk_out("res_end", 4'h0, 4'h0);
    step(1);
    chk_out("res_rise", 4'hB, 4'hB);
    step(1);
    chk_out("no_leak", 4'hB, 4'h0);
    AResetHN = 1'b0;
    #1;
    chk_out("arst", 4'h0, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_frac_mc.md
# clk_div_frac_mc

Multi-channel, IO-programmable fractional clock divider in the AClkH domain. It produces CChCnt independent divided clocks with near-50 % duty and an optional fractional half-period. Each channel also produces a one-cycle enable tick per period. Divider changes are glitch-free: they take effect only at period boundaries. A common sync input restarts all channels phase-aligned, so peripherals (UART, SPI, timers) can share one block instead of one fixed divider each.

## Interface
- CAddrBase, 16'h0000, IO base address; channel n occupies CAddrBase+4*n.
- CChCnt, 4, number of channels (1..8).
- CIntW, 12, integer half-period field width.
- CFraW, 4, fractional field width.
- CResetDiv, 32'h8000_0170, per-channel reset value of the control word.

- AClkH  in  1  clock
- AResetHN  in  1  reset. One clock; reset is asynchronous and active-low.
- AClkHEn  in  1  clock enable; when 0 every register holds
- AIoAddr  in  16  IO address
- AIoMosi  in  64  IO write data; control word is AIoMosi[31:0]
- AIoWrSize  in  4  write size; 4'h4 = 32-bit write, 4'h0 = no write
- AIoAddrAck  out  1  address in CAddrBase .. CAddrBase+4*CChCnt-1
- AIoAddrErr  out  1  address in range and AIoWrSize not in {4'h0, 4'h4}
- ASyncI  in  1  synchronous restart of all channels
- AClkOut  out  CChCnt  divided clocks, registered
- AClkEnO  out  CChCnt  one-cycle tick, registered, high in the first cycle AClkOut[n]=1

## Operation
- Control word fields:
  - [CFraW-1:0] = Fra
  - [CIntW+CFraW-1:CFraW] = Int
  - bit 31 = En
  - all other bits ignored
- A 32-bit write to channel n updates Shadow[n]. No other write size modifies state.
- Per-channel state: Active word, FCnt (CIntW+1 bits), FAcc (CFraW bits), FClkOut, FTick.
- Boundary = FCnt==0 and FClkOut==0. Idle is a permanent boundary.
- At a boundary:
  - Active <= Shadow.
  - If Shadow.En=1: S = FAcc+Fra (CFraW+1 bits), FAcc <= S[CFraW-1:0], FCnt <= Int+S[CFraW], FClkOut <= 1, FTick <= 1.
  - If Shadow.En=0: FCnt, FAcc and FClkOut stay 0.
- FClkOut=1 and FCnt==0: same accumulate/load using Active, FClkOut <= 0.
- Otherwise: FCnt <= FCnt-1.
- FTick <= 0 in every cycle except boundary-with-En.
- Half-period = Int+1+carry cycles. Mean period = 2*(Int+1)+2*Fra/2^CFraW cycles.
- Int all ones plus carry fits, because FCnt is one bit wider than Int; there is no wrap.
- Disable is glitch-free: a high phase always completes, then the low phase completes, then the channel goes idle.
- ASyncI=1 (with AClkHEn) forces FCnt, FAcc, FClkOut and FTick to 0 on all channels. The next cycle is a boundary for every channel, so all enabled channels rise together. ASyncI has priority over counting and over the boundary load.
- IO write in the same cycle as a boundary: the boundary loads the old Shadow; the new value is used at the next boundary.
- Reset:
  - Shadow and Active = CResetDiv.
  - FCnt, FAcc, FClkOut and FTick = 0.
  - AClkOut = 0 and AClkEnO = 0 while reset is held.

## Timing
- All outputs are registered except AIoAddrAck and AIoAddrErr, which are combinational.
- An enabled channel rises in the first enabled cycle after reset release, with AClkEnO=1 in that same cycle.
- A write in cycle t has its new divider take effect no earlier than the boundary after t. Worst case is one full old period.
- ASyncI in cycle t gives AClkOut=0 in t+1 and a rise on every enabled channel in t+2.
- Int=0, Fra=0 gives AClkOut toggling every cycle (divide by 2).

## Structure
- Package clk_div_pkg holds:
  - Field offsets: CFraLo=0, CEnBit=31.
  - Word width: 32.
  - Write-size constant: CWrSize32=4'h4.
  - Function computing Int+carry.
- Sub-module clk_div_frac_ch contains one channel: Active, FCnt, FAcc, FClkOut and FTick. It is instantiated CChCnt times.
- The top level holds address decode, Shadow registers and ASyncI fan-out.

## Test plan
- Reset release with default CResetDiv (Int=23, Fra=0, En=1), ch0 otherwise untouched -> AClkOut[0] period 48, high 24, AClkEnO[0] once per period coincident with the rise.
- Write ch1 Int=3, Fra=8 -> half-periods alternate 4,5 cycles, period 9, FAcc pattern 8,0,8,0.
- Write Int=0, Fra=0 to ch2 -> toggles every cycle. Then write En=0 mid-high-phase -> current high and low phases complete, then AClkOut[2] stays 0 and AClkEnO[2] never pulses.
- Two channels at different phases, pulse ASyncI -> both low at t+1, both rise with ticks at t+2.
- Write landing exactly on a boundary cycle -> the old divider is used for that period, the new one from the next boundary.
- Out-of-range address, and an in-range write with AIoWrSize=4'h2 -> Ack=0/Err=0 and Ack=1/Err=1 respectively; Shadow unchanged in both cases.
- Hold AClkHEn=0 for 10 cycles -> all outputs frozen and an IO write ignored; counting resumes where it stopped.
